// File: rtl/adt7310_pkg.sv
// Shared definitions for the ADT7310 measurement sequencer: state encoding
// and the byte/word widths used between the sequencer and the SPI transfer FSM.
package adt7310_pkg;

    localparam int BYTE_WIDTH = 8;
    localparam int WORD_WIDTH = 2 * BYTE_WIDTH;

    typedef enum logic [1:0] {
        stDisabled = 2'd0,
        stIdle     = 2'd1,
        stXfer     = 2'd2,
        stNotify   = 2'd3
    } state_t;

endpackage

// File: rtl/sensor_period_timer.sv
// Measurement-period down-counter. Preset loads the period value; Enable
// counts down towards zero and then holds. Zero flags an expired period.
module sensor_period_timer
    import adt7310_pkg::*;
#(
    parameter int Width = WORD_WIDTH
) (
    input  logic             Clk_i,
    input  logic             Reset_n_i,
    input  logic             Preset,
    input  logic             Enable,
    input  logic [Width-1:0] PresetValue,
    output logic             Zero
);

    logic [Width-1:0] count;

    // Load the period on Preset, otherwise count down while enabled and not yet expired.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            count <= '0;
        end else if (Preset) begin
            count <= PresetValue;
        end else if (Enable && (count != '0)) begin
            count <= count - Width'(1);
        end
    end

    assign Zero = (count == '0);

endmodule

// File: rtl/adt7310_sensor_fsm.sv
// Periodic ADT7310 measurement sequencer. Kicks the SPI transfer FSM once per
// period, assembles the returned temperature word and reports it (with a
// one-cycle CPU interrupt) only when it moved by more than the threshold.
module adt7310_sensor_fsm
    import adt7310_pkg::*;
#(
    parameter int DataWidth = BYTE_WIDTH
) (
    input  logic                   Reset_n_i,
    input  logic                   Clk_i,
    input  logic                   Enable_i,
    output logic                   CpuIntr_o,
    output logic [2*DataWidth-1:0] SensorValue_o,
    output logic                   MeasureFSM_Start_o,
    input  logic                   MeasureFSM_Done_i,
    input  logic [DataWidth-1:0]   MeasureFSM_Byte0_i,
    input  logic [DataWidth-1:0]   MeasureFSM_Byte1_i,
    input  logic [WORD_WIDTH-1:0]  ParamCounterPreset_i,
    input  logic [2*DataWidth-1:0] ParamThreshold_i
);

    localparam int W = 2 * DataWidth;

    state_t         state;
    logic           timer_preset;
    logic           timer_enable;
    logic           timer_zero;
    logic           start;
    logic [W-1:0]   value;
    logic [W:0]     diff;
    logic [W:0]     abs_diff;
    logic           significant;

    // The start pulse is combinational so SPIFSM sees it in the same cycle the period expires.
    assign start              = (state == stIdle) && Enable_i && timer_zero;
    assign MeasureFSM_Start_o = start;

    // The timer runs only while idling; every other state (and the start cycle) reloads it.
    assign timer_enable = (state == stIdle);
    assign timer_preset = (state != stIdle) || start;

    sensor_period_timer #(
        .Width (WORD_WIDTH)
    ) u_timer (
        .Clk_i       (Clk_i),
        .Reset_n_i   (Reset_n_i),
        .Preset      (timer_preset),
        .Enable      (timer_enable),
        .PresetValue (ParamCounterPreset_i),
        .Zero        (timer_zero)
    );

    // One extra bit on the subtraction so that opposite-sign extremes cannot wrap.
    assign value       = {MeasureFSM_Byte1_i, MeasureFSM_Byte0_i};
    assign diff        = {value[W-1], value} - {SensorValue_o[W-1], SensorValue_o};
    assign abs_diff    = diff[W] ? (~diff + (W+1)'(1)) : diff;
    assign significant = (abs_diff > {1'b0, ParamThreshold_i});

    // Sequencer state, reported value and the registered interrupt pulse.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state         <= stDisabled;
            SensorValue_o <= '0;
            CpuIntr_o     <= 1'b0;
        end else begin
            CpuIntr_o <= 1'b0;
            case (state)
                stDisabled: begin
                    if (Enable_i) begin
                        state <= stIdle;
                    end
                end
                stIdle: begin
                    if (!Enable_i) begin
                        state <= stDisabled;
                    end else if (timer_zero) begin
                        state <= stXfer;
                    end
                end
                stXfer: begin
                    if (MeasureFSM_Done_i) begin
                        if (significant) begin
                            SensorValue_o <= value;
                            CpuIntr_o     <= 1'b1;
                            state         <= stNotify;
                        end else begin
                            state <= Enable_i ? stIdle : stDisabled;
                        end
                    end
                end
                stNotify: begin
                    state <= Enable_i ? stIdle : stDisabled;
                end
                default: begin
                    state <= stDisabled;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adt7310_sensor_fsm.sv
// Directed bench for the ADT7310 measurement sequencer with a simple SPIFSM
// model that stays busy for six cycles after each start pulse.
module tb_adt7310_sensor_fsm;

    logic        Clk_i;
    logic        Reset_n_i;
    logic        Enable_i;
    logic        CpuIntr_o;
    logic [15:0] SensorValue_o;
    logic        MeasureFSM_Start_o;
    logic        MeasureFSM_Done_i;
    logic [7:0]  MeasureFSM_Byte0_i;
    logic [7:0]  MeasureFSM_Byte1_i;
    logic [15:0] ParamCounterPreset_i;
    logic [15:0] ParamThreshold_i;

    int          checks;
    int          errors;
    int          startCount;
    int          doneCount;
    int          measStarts;
    int          measDones;
    int          busyCnt;
    logic [15:0] modelValue;

    adt7310_sensor_fsm #(
        .DataWidth (8)
    ) dut (
        .Reset_n_i            (Reset_n_i),
        .Clk_i                (Clk_i),
        .Enable_i             (Enable_i),
        .CpuIntr_o            (CpuIntr_o),
        .SensorValue_o        (SensorValue_o),
        .MeasureFSM_Start_o   (MeasureFSM_Start_o),
        .MeasureFSM_Done_i    (MeasureFSM_Done_i),
        .MeasureFSM_Byte0_i   (MeasureFSM_Byte0_i),
        .MeasureFSM_Byte1_i   (MeasureFSM_Byte1_i),
        .ParamCounterPreset_i (ParamCounterPreset_i),
        .ParamThreshold_i     (ParamThreshold_i)
    );

    // 10-time-unit clock
    initial begin
        Clk_i = 1'b0;
        forever #5 Clk_i = ~Clk_i;
    end

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive the level inputs of the sequencer
    task automatic applyStimulus(input logic en, input logic [15:0] preset, input logic [15:0] thr);
        Enable_i             = en;
        ParamCounterPreset_i = preset;
        ParamThreshold_i     = thr;
    endtask

    // SPIFSM model: reacts just after each rising edge, busy for six cycles per start
    initial begin
        MeasureFSM_Done_i  = 1'b1;
        MeasureFSM_Byte0_i = 8'h00;
        MeasureFSM_Byte1_i = 8'h00;
        busyCnt            = 0;
        forever begin
            @(posedge Clk_i);
            #1;
            if (!Reset_n_i) begin
                MeasureFSM_Done_i = 1'b1;
                busyCnt           = 0;
            end else if (busyCnt > 0) begin
                checkOutput("start_while_busy", {31'd0, MeasureFSM_Start_o}, 32'd0);
                busyCnt--;
                if (busyCnt == 0) begin
                    MeasureFSM_Done_i = 1'b1;
                    {MeasureFSM_Byte1_i, MeasureFSM_Byte0_i} = modelValue;
                    doneCount++;
                end
            end else if (MeasureFSM_Start_o) begin
                checkOutput("start_with_done", {31'd0, MeasureFSM_Done_i}, 32'd1);
                MeasureFSM_Done_i = 1'b0;
                {MeasureFSM_Byte1_i, MeasureFSM_Byte0_i} = 16'hA5A5;
                busyCnt = 6;
                startCount++;
            end
        end
    end

    // One full measurement: wait for the start, wait for completion, check the result
    task automatic runMeasurement(input logic [15:0] value, input int expCount, input logic expIntr,
                                  input logic [15:0] expSensor, input bit dropEnable, input string tag);
        int cnt;
        modelValue = value;
        measStarts++;
        measDones++;
        cnt = 0;
        while (startCount < measStarts && cnt < 200) begin
            @(negedge Clk_i);
            cnt++;
        end
        checkOutput({tag, "_started"}, startCount, measStarts);
        if (expCount >= 0) begin
            checkOutput({tag, "_start_delay"}, cnt, expCount);
        end
        if (dropEnable) begin
            @(negedge Clk_i);
            @(negedge Clk_i);
            Enable_i = 1'b0;
        end
        cnt = 0;
        while (doneCount < measDones && cnt < 50) begin
            @(negedge Clk_i);
            cnt++;
        end
        checkOutput({tag, "_done"}, doneCount, measDones);
        @(negedge Clk_i);
        checkOutput({tag, "_intr"}, {31'd0, CpuIntr_o}, {31'd0, expIntr});
        checkOutput({tag, "_value"}, {16'd0, SensorValue_o}, {16'd0, expSensor});
        @(negedge Clk_i);
        checkOutput({tag, "_intr_end"}, {31'd0, CpuIntr_o}, 32'd0);
        checkOutput({tag, "_value_hold"}, {16'd0, SensorValue_o}, {16'd0, expSensor});
    endtask

    // Runaway guard
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        int cnt;
        checks     = 0;
        errors     = 0;
        startCount = 0;
        doneCount  = 0;
        measStarts = 0;
        measDones  = 0;
        modelValue = 16'h0000;
        Reset_n_i  = 1'b0;
        applyStimulus(1'b0, 16'd3, 16'h0010);

        repeat (3) @(negedge Clk_i);
        checkOutput("reset_intr", {31'd0, CpuIntr_o}, 32'd0);
        checkOutput("reset_value", {16'd0, SensorValue_o}, 32'd0);
        checkOutput("reset_start", {31'd0, MeasureFSM_Start_o}, 32'd0);

        Reset_n_i = 1'b1;
        applyStimulus(1'b1, 16'd3, 16'h0010);
        runMeasurement(16'h0190, 4, 1'b1, 16'h0190, 1'b0, "m1_first");
        runMeasurement(16'h0198, 3, 1'b0, 16'h0190, 1'b0, "m2_below");
        runMeasurement(16'h01A0, 2, 1'b0, 16'h0190, 1'b0, "m3_equal");
        runMeasurement(16'h01A1, 2, 1'b1, 16'h01A1, 1'b0, "m4_above");
        runMeasurement(16'h0008, 3, 1'b1, 16'h0008, 1'b0, "m5_down");
        runMeasurement(16'hFFF0, 3, 1'b1, 16'hFFF0, 1'b0, "m6_sign_cross");
        runMeasurement(16'h7FFF, 3, 1'b1, 16'h7FFF, 1'b0, "m7_max");
        runMeasurement(16'h8000, 3, 1'b1, 16'h8000, 1'b0, "m8_no_wrap");

        runMeasurement(16'h0100, 3, 1'b1, 16'h0100, 1'b1, "m9_drop_enable");
        repeat (20) @(negedge Clk_i);
        checkOutput("no_start_disabled", startCount, measStarts);

        applyStimulus(1'b1, 16'd3, 16'h0010);
        runMeasurement(16'h0100, 4, 1'b0, 16'h0100, 1'b0, "m10_reenable");

        applyStimulus(1'b1, 16'd0, 16'h0010);
        runMeasurement(16'h0105, 2, 1'b0, 16'h0100, 1'b0, "m11_preset_reload");
        runMeasurement(16'h0110, 0, 1'b0, 16'h0100, 1'b0, "m12_p0_equal");
        runMeasurement(16'h0200, 0, 1'b1, 16'h0200, 1'b0, "m13_p0_notify");
        runMeasurement(16'h0300, 0, 1'b1, 16'h0300, 1'b0, "m14_p0_after_notify");

        modelValue = 16'h0400;
        measStarts++;
        cnt = 0;
        while (startCount < measStarts && cnt < 200) begin
            @(negedge Clk_i);
            cnt++;
        end
        checkOutput("rst_xfer_started", startCount, measStarts);
        repeat (3) @(negedge Clk_i);
        Reset_n_i = 1'b0;
        Enable_i  = 1'b0;
        #1;
        checkOutput("rst_xfer_intr", {31'd0, CpuIntr_o}, 32'd0);
        checkOutput("rst_xfer_value", {16'd0, SensorValue_o}, 32'd0);
        checkOutput("rst_xfer_start", {31'd0, MeasureFSM_Start_o}, 32'd0);
        repeat (3) @(negedge Clk_i);
        Reset_n_i = 1'b1;
        @(negedge Clk_i);
        checkOutput("rst_release_value", {16'd0, SensorValue_o}, 32'd0);
        applyStimulus(1'b1, 16'd3, 16'h0010);
        runMeasurement(16'h0050, 4, 1'b1, 16'h0050, 1'b0, "m15_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
